sequence_lock_checker: RTL
==========================

Name: sequence_lock_checker

Overview:
- Responder end of the four-line code sequencer: monitors in1..in4 plus the ativar strobe driven by the sequencer machine and validates the presented 4-bit code against a stored constant.
- On match, asserts liberado for a fixed window. On mismatch, pulses erro and counts failures; repeated failures force a timed lockout.
- Sits between the code sequencer and the actuator/status LEDs of the project board.

Parameters:
- CODE, 4'b1001, expected code, packed {in1,in2,in3,in4}, in1 = MSB
- MAX_TRIES, 3, consecutive failures that trigger lockout (>=1)
- GRANT_CYCLES, 8, cycles liberado stays high (>=1)
- LOCK_CYCLES, 16, cycles bloqueado stays high (>=1)
- TW, $clog2(MAX_TRIES+1), width of failure counter (derived; not overridden)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous reset, active-high
- in1, in2, in3, in4  in  1 each  code lines from sequencer
- ativar  in  1  level strobe from sequencer; an attempt = 0->1 transition
- liberado  out  1  access granted window
- erro  out  1  one-cycle pulse per failed attempt
- bloqueado  out  1  lockout active
- tentativas  out  TW  current consecutive-failure count

Behaviour:
- Reset (rst=1 at posedge): state IDLE, liberado=erro=bloqueado=0, tentativas=0, code_reg=0, timer=0, ativar_q=1. ativar_q resets to 1 so an ativar already held high out of reset is NOT an attempt; it must be seen low first.
- Edge detect: ativar_q <= ativar every cycle in every state. rise = ativar & ~ativar_q.
- States: IDLE, CHECK, GRANT, FAIL, LOCKED (encoding in package).
- IDLE: on rise at posedge k, capture code_reg <= {in1,in2,in3,in4}; go CHECK at k+1.
- CHECK (one cycle): if code_reg == CODE, then tentativas <= 0, liberado <= 1, timer <= GRANT_CYCLES-1, go GRANT. Else erro <= 1, tentativas <= tentativas+1, go FAIL. Outputs are visible from cycle k+2.
- GRANT: liberado=1. Timer decrements. At 0, liberado <= 0, go IDLE. Total liberado high time is exactly GRANT_CYCLES.
- FAIL (one cycle): erro <= 0. If tentativas == MAX_TRIES, then bloqueado <= 1, timer <= LOCK_CYCLES-1, go LOCKED. Else go IDLE.
- LOCKED: bloqueado=1; timer decrements. At 0, bloqueado <= 0, tentativas <= 0, go IDLE.
- Rises in CHECK/GRANT/FAIL/LOCKED are discarded, not queued. ativar_q still tracks, so a level held across the return to IDLE does not retrigger.
- Rise in the same cycle the FSM re-enters IDLE is discarded; only rises sampled while in IDLE count.
- tentativas saturates at MAX_TRIES and never wraps.
- rst mid-GRANT/LOCKED: immediate return to reset values next cycle; lockout and count are lost.
- in1..in4 are don't-care except at the capture edge.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- LOCKOUT_EN.
- Defined: behaviour as above.
- Undefined: LOCKED state and lock timer are not built. bloqueado is tied 0. FAIL always returns to IDLE. tentativas saturates at MAX_TRIES and clears only on success or reset.

Decomposition:
- Shared package: state encoding typedef (IDLE..LOCKED), default CODE constant, and timer width helper (clog2 of max(GRANT_CYCLES, LOCK_CYCLES)).
- One natural sub-module: rise_detect (single-bit registered 0->1 detector with a reset-value parameter), reusable for other strobes in the project.

Test Plan:
- Reset with ativar=1 held, then ativar stays 1 for 5 cycles -> no attempt, all outputs 0, tentativas=0.
- ins=1,0,0,1, ativar 0->1 at edge k -> liberado high from k+2 for exactly 8 cycles, erro never asserted, tentativas=0.
- ins=1,1,0,1, rise -> erro one-cycle pulse at k+2, tentativas=1, liberado stays 0. Then a correct code attempt -> grant, tentativas back to 0.
- Three wrong attempts (ativar toggled low between) -> tentativas=3, bloqueado high 16 cycles. A correct code during lockout is ignored. After lockout, tentativas=0 and a correct code grants.
- rst asserted at 4th cycle of GRANT -> liberado=0 next cycle, state IDLE, subsequent held ativar does not retrigger until seen low.
- LOCKOUT_EN undefined, five wrong attempts -> bloqueado never asserted, tentativas saturates at 3, erro pulses 5 times.

Source files
------------

// File: rtl/sequence_lock_checker_pkg.sv
// rtl/sequence_lock_checker_pkg.sv - shared types and constants for the code lock checker
//
// Contents:
//   state_t      FSM state encoding (IDLE, CHECK, GRANT, FAIL, LOCKED)
//   DEFAULT_CODE default expected code, packed {in1,in2,in3,in4}, in1 = MSB
//   timer_width  bits needed to hold max(GRANT_CYCLES, LOCK_CYCLES)-1, at least 1
package sequence_lock_checker_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_GRANT  = 3'd2,
    S_FAIL   = 3'd3,
    S_LOCKED = 3'd4
  } state_t;

  localparam logic [3:0] DEFAULT_CODE = 4'b1001;

  // The timer is loaded with (window length - 1) and counts down to zero,
  // so clog2 of the longer window is enough; keep one bit as a floor.
  function automatic int timer_width(input int grant_cycles, input int lock_cycles);
    int m;
    m = (grant_cycles > lock_cycles) ? grant_cycles : lock_cycles;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sequence_lock_checker_rise_detect.sv
// rtl/sequence_lock_checker_rise_detect.sv - registered 0->1 detector for a single-bit strobe
//
// Ports:
//   clk   in   system clock, posedge
//   rst   in   synchronous reset, active-high
//   d     in   strobe level being watched
//   rise  out  high for the cycle where d is 1 and its registered copy is 0
//
// Parameter RESET_VAL sets the registered copy on reset. Resetting it to 1
// means a strobe already high coming out of reset is not a rise until it
// has been seen low.
module sequence_lock_checker_rise_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= RESET_VAL;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/sequence_lock_checker.sv
// rtl/sequence_lock_checker.sv - validates a 4-line code on each ativar rise, grants or counts failures
//
// Ports:
//   clk            in   system clock, all logic on posedge
//   rst            in   synchronous reset, active-high
//   in1..in4       in   code lines from the sequencer, sampled only on an accepted rise
//   ativar         in   level strobe; an attempt is a 0->1 transition seen while idle
//   liberado       out  access-granted window, GRANT_CYCLES long
//   erro           out  one-cycle pulse per failed attempt
//   bloqueado      out  lockout window, LOCK_CYCLES long
//   tentativas     out  consecutive-failure count, saturating at MAX_TRIES
//
// Build option: define LOCKOUT_EN to build the timed lockout. Without it the
// LOCKED state and its timer are absent, bloqueado is tied low and the
// failure count only clears on a successful attempt or reset.
module sequence_lock_checker
  import sequence_lock_checker_pkg::*;
#(
  parameter logic [3:0] CODE         = DEFAULT_CODE,
  parameter int         MAX_TRIES    = 3,
  parameter int         GRANT_CYCLES = 8,
  parameter int         LOCK_CYCLES  = 16,
  localparam int        TW           = $clog2(MAX_TRIES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in1,
  input  logic          in2,
  input  logic          in3,
  input  logic          in4,
  input  logic          ativar,
  output logic          liberado,
  output logic          erro,
  output logic          bloqueado,
  output logic [TW-1:0] tentativas
);

  localparam int            TMW        = timer_width(GRANT_CYCLES, LOCK_CYCLES);
  localparam logic [TMW-1:0] GRANT_LOAD = TMW'(GRANT_CYCLES - 1);
  localparam logic [TW-1:0]  MAX_T      = TW'(MAX_TRIES);
`ifdef LOCKOUT_EN
  localparam logic [TMW-1:0] LOCK_LOAD  = TMW'(LOCK_CYCLES - 1);
`endif

  state_t         state;
  logic [3:0]     code_reg;
  logic [TMW-1:0] timer;
  logic           rise;

  // Reset value 1: a strobe held high out of reset must drop before it counts.
  sequence_lock_checker_rise_detect #(
    .RESET_VAL(1'b1)
  ) u_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (ativar),
    .rise (rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      code_reg   <= '0;
      timer      <= '0;
      liberado   <= 1'b0;
      erro       <= 1'b0;
      tentativas <= '0;
`ifdef LOCKOUT_EN
      bloqueado  <= 1'b0;
`endif
    end else begin
      case (state)
        // Only rises sampled here count; rises in any other state are dropped.
        S_IDLE: begin
          if (rise) begin
            code_reg <= {in1, in2, in3, in4};
            state    <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (code_reg == CODE) begin
            tentativas <= '0;
            liberado   <= 1'b1;
            timer      <= GRANT_LOAD;
            state      <= S_GRANT;
          end else begin
            erro <= 1'b1;
            if (tentativas != MAX_T) begin
              tentativas <= tentativas + TW'(1);
            end
            state <= S_FAIL;
          end
        end

        S_GRANT: begin
          if (timer == '0) begin
            liberado <= 1'b0;
            state    <= S_IDLE;
          end else begin
            timer <= timer - TMW'(1);
          end
        end

        S_FAIL: begin
          erro <= 1'b0;
`ifdef LOCKOUT_EN
          if (tentativas == MAX_T) begin
            bloqueado <= 1'b1;
            timer     <= LOCK_LOAD;
            state     <= S_LOCKED;
          end else begin
            state <= S_IDLE;
          end
`else
          state <= S_IDLE;
`endif
        end

`ifdef LOCKOUT_EN
        // Lockout expiry forgives the accumulated failures.
        S_LOCKED: begin
          if (timer == '0) begin
            bloqueado  <= 1'b0;
            tentativas <= '0;
            state      <= S_IDLE;
          end else begin
            timer <= timer - TMW'(1);
          end
        end
`endif

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifndef LOCKOUT_EN
  assign bloqueado = 1'b0;
`endif

endmodule
